msrv32_decode_stage: RTL and testbench
======================================

Name: msrv32_decode_stage

Overview:
Registered, back-pressurable RV32 decode stage that supersedes the purely combinational decoder. Decodes opcode/funct fields and address alignment into a control bundle, with optional M-extension and Zicsr decode. The bundle is held in a 2-entry skid pipeline (valid/ready on both sides) between fetch and execute. Flushed by trap, with a saturating illegal-instruction counter for debug.

Parameters:
ENABLE_M, 1, 1 = decode MUL/DIV (funct7=0000001) as legal and raise md_req_out; 0 = treat as illegal
ENABLE_CSR, 1, 1 = decode SYSTEM CSR ops (funct3!=000) as legal; 0 = illegal
CNT_W, 8, width of illegal_cnt_out

Ports:
ms_riscv32_mp_clk_in  in  1  clock, rising edge
ms_riscv32_mp_rst_n_in  in  1  reset, asynchronous, active-low
in_valid_in  in  1  instruction fields valid
in_ready_out  out  1  stage can accept
opcode_in  in  7  instr[6:0]
funct3_in  in  3  instr[14:12]
funct7_in  in  7  instr[31:25]
iadder_out_1_to_0_in  in  2  low bits of computed address/target
flush_in  in  1  trap taken; kill all held entries
out_valid_out  out  1  bundle valid
out_ready_in  in  1  execute accepts bundle
wb_mux_sel_out  out  3  0 ALU, 1 LOAD, 2 LUI imm, 3 AUIPC iadder, 4 CSR, 5 PC+4
imm_type_out  out  3  0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR-uimm
alu_opcode_out  out  4  {funct7[5] (OP SUB/SRA, OP-IMM SRAI only), funct3}
alu_src_out  out  1  1 = rs2, 0 = immediate
iadder_src_out  out  1  1 = rs1 (loads/stores/JALR), 0 = PC
load_size_out  out  2  funct3[1:0]
load_unsigned_out  out  1  funct3[2]
mem_wr_req_out  out  1  store, qualified
rf_wr_en_out  out  1  register write, qualified
csr_wr_en_out  out  1  CSR write, qualified
csr_op_out  out  3  funct3 on SYSTEM
md_req_out  out  1  M-extension op, qualified
illegal_instr_out  out  1  unsupported opcode/funct
misaligned_load_out  out  1  load address misaligned
misaligned_store_out  out  1  store address misaligned
misaligned_instr_out  out  1  JAL/JALR target bit1 set
illegal_cnt_out  out  CNT_W  saturating count of illegal bundles delivered

Behaviour:
- Reset (async, rst_n=0): both entries invalid, all outputs 0, counter 0; in_ready_out=1 from the first cycle after release.
- Latency: fields accepted on in_valid&&in_ready appear on outputs the next cycle with out_valid_out=1.
- Skid: main + skid entry. in_ready_out = !skid_valid (registered). If main holds a valid bundle not taken and an input is accepted, it goes to skid; in_ready drops next cycle. On out handshake, skid moves to main (same cycle), or main loads new input, or main empties.
- Simultaneous out handshake + input accept with skid empty: main replaced by new bundle, no bubble.
- flush_in: next edge clears both valids; input presented that cycle is dropped; output handshake that cycle still counts. flush overrides everything except reset.
- Qualifiers (rf_wr_en, mem_wr_req, csr_wr_en, md_req) are 0 whenever out_valid_out=0 or illegal_instr_out=1. Other payload outputs hold their last value when invalid.
- Legal set: LUI, AUIPC, JAL, JALR (f3=000), BRANCH (f3!=010/011), LOAD (f3 in 000,001,010,100,101), STORE (f3 000..010), OP-IMM (shift funct7 check), OP (funct7 0000000/0100000 per f3; 0000001 iff ENABLE_M), FENCE, SYSTEM (f3=000 ECALL/EBREAK/MRET; f3!=000,100 iff ENABLE_CSR). Anything else is illegal. Opcode bits[1:0]!=11 is illegal.
- Misalignment: word access needs addr[1:0]=00; halfword needs addr[0]=0; byte never misaligned. Flags are meaningful only for LOAD/STORE, else 0.
- csr_wr_en: CSRRW/CSRRWI always; CSRRS/RC(I) only if rs1/uimm nonzero — not visible here, so asserted for all CSR ops; execute gates it.
- Counter increments on out handshake with illegal_instr_out=1; saturates at all-ones; not cleared by flush.

Decomposition:
- Package msrv32_pkg: opcode constants, WB_* select codes, IMM_* types, ALU op encodings, funct7 constants.
- Sub-module msrv32_decode_comb: pure combinational field-to-bundle decode, parameterised by ENABLE_M/ENABLE_CSR. The top holds the skid registers, handshake and counter.

Test Plan:
- ADDI (0010011, f3 000), out_ready=1 -> next cycle out_valid=1, wb_sel=0, imm_type=0, alu_src=0, rf_wr_en=1, illegal=0.
- OP funct7=0000001 f3=000: ENABLE_M=1 -> md_req=1, illegal=0; ENABLE_M=0 -> illegal=1, rf_wr_en=0, counter 0->1.
- LW (0000011 f3 010) addr=10 -> misaligned_load=1; LH addr=10 -> 0; SH addr=01 -> misaligned_store=1, mem_wr_req=1.
- out_ready=0 for 3 cycles with in_valid=1 -> two bundles held, in_ready=0 from cycle 2; release -> both delivered in order on consecutive cycles, no loss or duplication.
- flush_in with both entries full plus input presented -> next cycle out_valid=0, in_ready=1, dropped input never appears.
- 256 illegal bundles with CNT_W=8 -> counter stays 255; async reset mid-stream -> outputs 0 immediately, counter 0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared decode constants and control bundle type
//
// Purpose: opcode constants, write-back select codes, immediate types, ALU
// op encodings, funct7 constants and the decoded control bundle used by
// msrv32_decode_comb and msrv32_decode_stage.
// Ports: none (package).
package msrv32_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Write-back mux select
   localparam logic [2:0] WB_ALU   = 3'd0;
   localparam logic [2:0] WB_LOAD  = 3'd1;
   localparam logic [2:0] WB_LUI   = 3'd2;
   localparam logic [2:0] WB_AUIPC = 3'd3;
   localparam logic [2:0] WB_CSR   = 3'd4;
   localparam logic [2:0] WB_PC4   = 3'd5;

   // Immediate formats
   localparam logic [2:0] IMM_I   = 3'd0;
   localparam logic [2:0] IMM_S   = 3'd1;
   localparam logic [2:0] IMM_B   = 3'd2;
   localparam logic [2:0] IMM_U   = 3'd3;
   localparam logic [2:0] IMM_J   = 3'd4;
   localparam logic [2:0] IMM_CSR = 3'd5;

   // funct7 patterns
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // ALU op encoding: {alt bit, funct3}
   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;

   typedef struct packed {
      logic [2:0] wb_mux_sel;
      logic [2:0] imm_type;
      logic [3:0] alu_opcode;
      logic       alu_src;
      logic       iadder_src;
      logic [1:0] load_size;
      logic       load_unsigned;
      logic       mem_wr_req;
      logic       rf_wr_en;
      logic       csr_wr_en;
      logic [2:0] csr_op;
      logic       md_req;
      logic       illegal;
      logic       mis_load;
      logic       mis_store;
      logic       mis_instr;
   } ctrl_t;

   // Access size is funct3[1:0]: 00 byte, 01 half, 10 word.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr);
      case (size)
         2'b10:   is_misaligned = (addr != 2'b00);
         2'b01:   is_misaligned = addr[0];
         default: is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/msrv32_decode_comb.sv
// rtl/msrv32_decode_comb.sv - combinational RV32 field-to-control decode
//
// Purpose: maps opcode/funct3/funct7 and the low address bits to a ctrl_t
// bundle. ENABLE_M / ENABLE_CSR select whether M-extension and Zicsr ops
// are legal.
// Ports:
//   opcode   in  7   instr[6:0]
//   funct3   in  3   instr[14:12]
//   funct7   in  7   instr[31:25]
//   addr_lo  in  2   low bits of computed address/target
//   ctrl     out     decoded control bundle (qualifiers already cleared when illegal)
module msrv32_decode_comb
   import msrv32_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b1,
   parameter bit ENABLE_CSR = 1'b1
) (
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic [1:0] addr_lo,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl               = '0;
      ctrl.alu_opcode    = {1'b0, funct3};
      ctrl.load_size     = funct3[1:0];
      ctrl.load_unsigned = funct3[2];

      // Compressed encodings are not supported; the case default also
      // catches them, the explicit test just makes the intent obvious.
      if (opcode[1:0] != 2'b11) begin
         ctrl.illegal = 1'b1;
      end else begin
         case (opcode)
            OPC_LUI: begin
               ctrl.wb_mux_sel = WB_LUI;
               ctrl.imm_type   = IMM_U;
               ctrl.rf_wr_en   = 1'b1;
            end
            OPC_AUIPC: begin
               ctrl.wb_mux_sel = WB_AUIPC;
               ctrl.imm_type   = IMM_U;
               ctrl.rf_wr_en   = 1'b1;
            end
            OPC_JAL: begin
               ctrl.wb_mux_sel = WB_PC4;
               ctrl.imm_type   = IMM_J;
               ctrl.rf_wr_en   = 1'b1;
               ctrl.mis_instr  = addr_lo[1];
            end
            OPC_JALR: begin
               ctrl.wb_mux_sel = WB_PC4;
               ctrl.imm_type   = IMM_I;
               ctrl.iadder_src = 1'b1;
               ctrl.rf_wr_en   = 1'b1;
               ctrl.mis_instr  = addr_lo[1];
               ctrl.illegal    = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
               ctrl.imm_type = IMM_B;
               ctrl.alu_src  = 1'b1;
               ctrl.illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
               ctrl.wb_mux_sel = WB_LOAD;
               ctrl.imm_type   = IMM_I;
               ctrl.iadder_src = 1'b1;
               ctrl.rf_wr_en   = 1'b1;
               ctrl.mis_load   = is_misaligned(funct3[1:0], addr_lo);
               ctrl.illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                 (funct3 == 3'b111);
            end
            OPC_STORE: begin
               ctrl.imm_type   = IMM_S;
               ctrl.iadder_src = 1'b1;
               ctrl.mem_wr_req = 1'b1;
               ctrl.mis_store  = is_misaligned(funct3[1:0], addr_lo);
               ctrl.illegal    = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
               ctrl.wb_mux_sel = WB_ALU;
               ctrl.imm_type   = IMM_I;
               ctrl.rf_wr_en   = 1'b1;
               // funct7 only exists for the shift-immediate forms
               if (funct3 == 3'b001) begin
                  ctrl.illegal = (funct7 != F7_BASE);
               end else if (funct3 == 3'b101) begin
                  ctrl.illegal       = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                  ctrl.alu_opcode[3] = funct7[5];
               end
            end
            OPC_OP: begin
               ctrl.wb_mux_sel    = WB_ALU;
               ctrl.alu_src       = 1'b1;
               ctrl.rf_wr_en      = 1'b1;
               ctrl.alu_opcode[3] = funct7[5];
               case (funct7)
                  F7_BASE:   ctrl.illegal = 1'b0;
                  F7_ALT:    ctrl.illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                  F7_MULDIV: begin
                     ctrl.md_req  = ENABLE_M;
                     ctrl.illegal = !ENABLE_M;
                  end
                  default:   ctrl.illegal = 1'b1;
               endcase
            end
            OPC_FENCE: begin
               ctrl.illegal = 1'b0;
            end
            OPC_SYSTEM: begin
               ctrl.csr_op = funct3;
               if (funct3 == 3'b100) begin
                  ctrl.illegal = 1'b1;
               end else if (funct3 != 3'b000) begin
                  // csr_wr_en is raised for every CSR op; execute suppresses
                  // the write for CSRRS/RC with a zero rs1/uimm.
                  ctrl.wb_mux_sel = WB_CSR;
                  ctrl.imm_type   = funct3[2] ? IMM_CSR : IMM_I;
                  ctrl.rf_wr_en   = 1'b1;
                  ctrl.csr_wr_en  = 1'b1;
                  ctrl.illegal    = !ENABLE_CSR;
               end
            end
            default: begin
               ctrl.illegal = 1'b1;
            end
         endcase
      end

      if (ctrl.illegal) begin
         ctrl.rf_wr_en   = 1'b0;
         ctrl.mem_wr_req = 1'b0;
         ctrl.csr_wr_en  = 1'b0;
         ctrl.md_req     = 1'b0;
      end
   end

endmodule

// File: rtl/msrv32_decode_stage.sv
// rtl/msrv32_decode_stage.sv - registered RV32 decode stage with 2-entry skid buffer
//
// Purpose: decodes instruction fields via msrv32_decode_comb and holds the
// result in a main + skid register pair with valid/ready on both sides.
// flush_in kills both entries; illegal_cnt_out saturating-counts illegal
// bundles handed to execute.
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_n_in   clock, async active-low reset
//   in_valid_in / in_ready_out                      fetch-side handshake
//   opcode_in, funct3_in, funct7_in, iadder_out_1_to_0_in   instruction fields
//   flush_in                                        trap flush
//   out_valid_out / out_ready_in                    execute-side handshake
//   *_out                                           decoded control bundle
//   illegal_cnt_out                                 saturating illegal counter
module msrv32_decode_stage
   import msrv32_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b1,
   parameter bit ENABLE_CSR = 1'b1,
   parameter int CNT_W      = 8
) (
   input  logic             ms_riscv32_mp_clk_in,
   input  logic             ms_riscv32_mp_rst_n_in,
   input  logic             in_valid_in,
   output logic             in_ready_out,
   input  logic [6:0]       opcode_in,
   input  logic [2:0]       funct3_in,
   input  logic [6:0]       funct7_in,
   input  logic [1:0]       iadder_out_1_to_0_in,
   input  logic             flush_in,
   output logic             out_valid_out,
   input  logic             out_ready_in,
   output logic [2:0]       wb_mux_sel_out,
   output logic [2:0]       imm_type_out,
   output logic [3:0]       alu_opcode_out,
   output logic             alu_src_out,
   output logic             iadder_src_out,
   output logic [1:0]       load_size_out,
   output logic             load_unsigned_out,
   output logic             mem_wr_req_out,
   output logic             rf_wr_en_out,
   output logic             csr_wr_en_out,
   output logic [2:0]       csr_op_out,
   output logic             md_req_out,
   output logic             illegal_instr_out,
   output logic             misaligned_load_out,
   output logic             misaligned_store_out,
   output logic             misaligned_instr_out,
   output logic [CNT_W-1:0] illegal_cnt_out
);

   ctrl_t            dec;
   ctrl_t            main_q;
   ctrl_t            skid_q;
   logic             main_valid;
   logic             skid_valid;
   logic             in_fire;
   logic             out_fire;
   logic             qual;
   logic [CNT_W-1:0] cnt_q;

   msrv32_decode_comb #(
      .ENABLE_M   (ENABLE_M),
      .ENABLE_CSR (ENABLE_CSR)
   ) u_decode (
      .opcode  (opcode_in),
      .funct3  (funct3_in),
      .funct7  (funct7_in),
      .addr_lo (iadder_out_1_to_0_in),
      .ctrl    (dec)
   );

   // in_ready is a pure register output: ready whenever the skid slot is free.
   assign in_ready_out = !skid_valid;
   assign in_fire      = in_valid_in && !skid_valid;
   assign out_fire     = main_valid && out_ready_in;

   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush_in) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_fire) begin
         if (skid_valid) begin
            // in_fire cannot be set here because skid_valid blocks ready
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end else if (in_fire) begin
            main_q <= dec;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (in_fire) begin
         if (main_valid) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
         end else begin
            main_q     <= dec;
            main_valid <= 1'b1;
         end
      end
   end

   // Counts delivered illegal bundles; a flush does not erase history.
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         cnt_q <= '0;
      end else if (out_fire && main_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign qual = main_valid && !main_q.illegal;

   assign out_valid_out        = main_valid;
   assign wb_mux_sel_out       = main_q.wb_mux_sel;
   assign imm_type_out         = main_q.imm_type;
   assign alu_opcode_out       = main_q.alu_opcode;
   assign alu_src_out          = main_q.alu_src;
   assign iadder_src_out       = main_q.iadder_src;
   assign load_size_out        = main_q.load_size;
   assign load_unsigned_out    = main_q.load_unsigned;
   assign mem_wr_req_out       = qual && main_q.mem_wr_req;
   assign rf_wr_en_out         = qual && main_q.rf_wr_en;
   assign csr_wr_en_out        = qual && main_q.csr_wr_en;
   assign csr_op_out           = main_q.csr_op;
   assign md_req_out           = qual && main_q.md_req;
   assign illegal_instr_out    = main_q.illegal;
   assign misaligned_load_out  = main_q.mis_load;
   assign misaligned_store_out = main_q.mis_store;
   assign misaligned_instr_out = main_q.mis_instr;
   assign illegal_cnt_out      = cnt_q;

endmodule

// File: tb/tb_msrv32_decode_stage.sv
// tb/tb_msrv32_decode_stage.sv - directed self-checking bench for msrv32_decode_stage
module tb_msrv32_decode_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [1:0] addr;
   logic       flush;
   logic       out_ready;

   // full-featured instance
   logic       in_ready, out_valid, alu_src, iadder_src, load_unsigned;
   logic       mem_wr, rf_wr, csr_wr, md_req, illegal, mis_load, mis_store, mis_instr;
   logic [2:0] wb_sel, imm_type, csr_op;
   logic [3:0] alu_op;
   logic [1:0] load_size;
   logic [7:0] cnt;

   // instance with M and CSR disabled
   logic       n_in_ready, n_out_valid, n_alu_src, n_iadder_src, n_load_unsigned;
   logic       n_mem_wr, n_rf_wr, n_csr_wr, n_md_req, n_illegal, n_mis_load, n_mis_store, n_mis_instr;
   logic [2:0] n_wb_sel, n_imm_type, n_csr_op;
   logic [3:0] n_alu_op;
   logic [1:0] n_load_size;
   logic [7:0] n_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   msrv32_decode_stage #(.ENABLE_M(1'b1), .ENABLE_CSR(1'b1), .CNT_W(8)) dut (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
      .in_valid_in(in_valid), .in_ready_out(in_ready),
      .opcode_in(opcode), .funct3_in(funct3), .funct7_in(funct7),
      .iadder_out_1_to_0_in(addr), .flush_in(flush),
      .out_valid_out(out_valid), .out_ready_in(out_ready),
      .wb_mux_sel_out(wb_sel), .imm_type_out(imm_type), .alu_opcode_out(alu_op),
      .alu_src_out(alu_src), .iadder_src_out(iadder_src), .load_size_out(load_size),
      .load_unsigned_out(load_unsigned), .mem_wr_req_out(mem_wr), .rf_wr_en_out(rf_wr),
      .csr_wr_en_out(csr_wr), .csr_op_out(csr_op), .md_req_out(md_req),
      .illegal_instr_out(illegal), .misaligned_load_out(mis_load),
      .misaligned_store_out(mis_store), .misaligned_instr_out(mis_instr),
      .illegal_cnt_out(cnt)
   );

   msrv32_decode_stage #(.ENABLE_M(1'b0), .ENABLE_CSR(1'b0), .CNT_W(8)) dut_nm (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
      .in_valid_in(in_valid), .in_ready_out(n_in_ready),
      .opcode_in(opcode), .funct3_in(funct3), .funct7_in(funct7),
      .iadder_out_1_to_0_in(addr), .flush_in(flush),
      .out_valid_out(n_out_valid), .out_ready_in(out_ready),
      .wb_mux_sel_out(n_wb_sel), .imm_type_out(n_imm_type), .alu_opcode_out(n_alu_op),
      .alu_src_out(n_alu_src), .iadder_src_out(n_iadder_src), .load_size_out(n_load_size),
      .load_unsigned_out(n_load_unsigned), .mem_wr_req_out(n_mem_wr), .rf_wr_en_out(n_rf_wr),
      .csr_wr_en_out(n_csr_wr), .csr_op_out(n_csr_op), .md_req_out(n_md_req),
      .illegal_instr_out(n_illegal), .misaligned_load_out(n_mis_load),
      .misaligned_store_out(n_mis_store), .misaligned_instr_out(n_mis_instr),
      .illegal_cnt_out(n_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [1:0] a);
      opcode   = op;
      funct3   = f3;
      funct7   = f7;
      addr     = a;
      in_valid = 1'b1;
   endtask

   // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0000000; addr = 2'b00;

      // reset state
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_rf_wr", rf_wr, 0);
      chk("rst_wb_sel", wb_sel, 0);
      chk("rst_cnt", cnt, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", in_ready, 1);

      // ADDI
      put(7'b0010011, 3'b000, 7'b0000000, 2'b00);
      step();
      in_valid = 1'b0;
      chk("addi_valid", out_valid, 1);
      chk("addi_wb", wb_sel, 0);
      chk("addi_imm", imm_type, 0);
      chk("addi_alu_src", alu_src, 0);
      chk("addi_alu_op", alu_op, 4'b0000);
      chk("addi_rf_wr", rf_wr, 1);
      chk("addi_illegal", illegal, 0);
      step();
      chk("addi_drained", out_valid, 0);
      chk("idle_rf_wr_gated", rf_wr, 0);

      // MUL: legal with M, illegal without
      put(7'b0110011, 3'b000, 7'b0000001, 2'b00);
      step();
      in_valid = 1'b0;
      chk("mul_md_req", md_req, 1);
      chk("mul_illegal", illegal, 0);
      chk("mul_rf_wr", rf_wr, 1);
      chk("mul_nm_illegal", n_illegal, 1);
      chk("mul_nm_rf_wr", n_rf_wr, 0);
      chk("mul_nm_md_req", n_md_req, 0);
      chk("mul_nm_cnt_before", n_cnt, 0);
      step();
      chk("mul_nm_cnt_after", n_cnt, 1);
      chk("mul_cnt_after", cnt, 0);

      // SUB / SRAI alternate bit
      put(7'b0110011, 3'b000, 7'b0100000, 2'b00);
      step();
      chk("sub_alu_op", alu_op, 4'b1000);
      chk("sub_alu_src", alu_src, 1);
      put(7'b0010011, 3'b101, 7'b0100000, 2'b00);
      step();
      chk("srai_alu_op", alu_op, 4'b1101);

      // loads / stores / jumps / csr streamed back to back
      put(7'b0000011, 3'b010, 7'b0000000, 2'b10);          // LW @ ..10
      step();
      chk("lw_mis_load", mis_load, 1);
      chk("lw_wb", wb_sel, 1);
      chk("lw_iadder_src", iadder_src, 1);
      put(7'b0000011, 3'b001, 7'b0000000, 2'b10);          // LH @ ..10
      step();
      chk("lh_mis_load", mis_load, 0);
      chk("lh_size", load_size, 2'b01);
      put(7'b0100011, 3'b001, 7'b0000000, 2'b01);          // SH @ ..01
      step();
      chk("sh_mis_store", mis_store, 1);
      chk("sh_mem_wr", mem_wr, 1);
      chk("sh_rf_wr", rf_wr, 0);
      chk("sh_imm", imm_type, 1);
      put(7'b1100111, 3'b000, 7'b0000000, 2'b10);          // JALR target ..10
      step();
      chk("jalr_mis_instr", mis_instr, 1);
      chk("jalr_wb", wb_sel, 5);
      chk("jalr_mis_load", mis_load, 0);
      put(7'b1110011, 3'b001, 7'b0000000, 2'b00);          // CSRRW
      step();
      in_valid = 1'b0;
      chk("csrrw_wb", wb_sel, 4);
      chk("csrrw_csr_wr", csr_wr, 1);
      chk("csrrw_csr_op", csr_op, 1);
      chk("csrrw_nm_illegal", n_illegal, 1);
      chk("csrrw_nm_csr_wr", n_csr_wr, 0);
      step();
      chk("stream_drained", out_valid, 0);
      chk("nm_cnt_two", n_cnt, 2);

      // back-pressure: LUI, AUIPC, JAL with out_ready low for three edges
      out_ready = 1'b0;
      put(7'b0110111, 3'b000, 7'b0000000, 2'b00);          // LUI
      step();
      chk("bp1_valid", out_valid, 1);
      chk("bp1_wb", wb_sel, 2);
      chk("bp1_in_ready", in_ready, 1);
      put(7'b0010111, 3'b000, 7'b0000000, 2'b00);          // AUIPC
      step();
      chk("bp2_in_ready", in_ready, 0);
      chk("bp2_wb", wb_sel, 2);
      put(7'b1101111, 3'b000, 7'b0000000, 2'b00);          // JAL (held off)
      step();
      chk("bp3_in_ready", in_ready, 0);
      chk("bp3_wb", wb_sel, 2);
      out_ready = 1'b1;
      step();
      chk("rel1_wb", wb_sel, 3);
      chk("rel1_valid", out_valid, 1);
      chk("rel1_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("rel2_wb", wb_sel, 5);
      chk("rel2_valid", out_valid, 1);
      step();
      chk("rel3_empty", out_valid, 0);

      // flush with both entries full and an input presented
      out_ready = 1'b0;
      put(7'b0110111, 3'b000, 7'b0000000, 2'b00);
      step();
      put(7'b0010111, 3'b000, 7'b0000000, 2'b00);
      step();
      chk("fl_full", in_ready, 0);
      put(7'b1101111, 3'b000, 7'b0000000, 2'b00);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("fl_out_valid", out_valid, 0);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_nm_out_valid", n_out_valid, 0);
      step();
      chk("fl_no_ghost", out_valid, 0);

      // 256 illegal bundles: counter saturates at 255
      put(7'b0000000, 3'b000, 7'b0000000, 2'b00);
      for (int i = 0; i < 256; i++) begin
         step();
         if (i == 0) begin
            chk("ill_flag", illegal, 1);
            chk("ill_rf_wr", rf_wr, 0);
            chk("ill_cnt_first", cnt, 0);
         end
      end
      in_valid = 1'b0;
      chk("sat_cnt_255", cnt, 255);
      step();
      chk("sat_cnt_hold", cnt, 255);
      chk("sat_nm_cnt", n_cnt, 255);

      // async reset mid-stream
      put(7'b0110111, 3'b000, 7'b0000000, 2'b00);
      step();
      chk("pre_rst_wb", wb_sel, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_wb", wb_sel, 0);
      chk("arst_rf_wr", rf_wr, 0);
      chk("arst_cnt", cnt, 0);
      chk("arst_nm_cnt", n_cnt, 0);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("final_in_ready", in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
